// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle datapath and its control unit.
// The datapath side supplies the instruction fields and ALU flags.
interface multicycle_control_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUControl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  ResultSrc, ALUControl, ALUSrcA,
    input  ALUSrcB, ImmSrc, RegSrc, RegWrite
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output ResultSrc, ALUControl, ALUSrcA,
    output ALUSrcB, ImmSrc, RegSrc, RegWrite
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle ARM control FSM with NZCV flag register
// and condition gating of all architectural writes.
module multicycle_control (
  input logic clk,
  input logic reset,
  multicycle_control_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB,
    MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state, state_n;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign unused_rn = ^bus.Instr[7:4];
  assign rd        = bus.Instr[3:0];

  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_hold;
  logic       fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    unique case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
    endcase
  end

  logic [1:0] dp_alu;
  logic       dp_valid;
  logic       dp_cmp;
  logic       dp_arith;
  logic       no_write;

  always_comb begin
    dp_alu   = 2'b00;
    dp_valid = 1'b1;
    dp_cmp   = 1'b0;
    dp_arith = 1'b0;
    no_write = 1'b0;
    case (funct[4:1])
      4'b0100: dp_arith = 1'b1;
      4'b0010: begin
        dp_alu   = 2'b01;
        dp_arith = 1'b1;
      end
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin
        dp_alu   = 2'b01;
        dp_arith = 1'b1;
        dp_cmp   = 1'b1;
        no_write = 1'b1;
      end
      default: begin
        dp_valid = 1'b0;
        no_write = 1'b1;
      end
    endcase
  end

  logic in_exec;
  logic flag_en;

  assign in_exec = (state == EXECR) || (state == EXECI);
  assign flag_en = in_exec & cond_hold & dp_valid
                 & (funct[0] | dp_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  // cond is latched before any flag change so writeback
  // sees the pre-update condition result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      cond_hold <= 1'b0;
    end else begin
      if (state == DECODE) cond_hold <= cond_ex;
      if (flag_en) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (dp_arith) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  logic       pc_write;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       rd_pc;

  assign rd_pc = (rd == 4'hF);

  always_comb begin
    state_n     = FETCH;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_control = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    case (state)
      FETCH: begin
        state_n    = DECODE;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        unique case (1'b1)
          op == 2'b01:             state_n = MEMADR;
          op == 2'b00 && !funct[5]: state_n = EXECR;
          op == 2'b00 && funct[5]:  state_n = EXECI;
          op == 2'b10:             state_n = BRANCH;
          op == 2'b11:             state_n = FETCH;
        endcase
      end
      MEMADR: begin
        state_n   = funct[0] ? MEMRD : MEMWR;
        alu_src_b = 2'b01;
      end
      MEMRD: begin
        state_n = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_hold;
        pc_write   = cond_hold & rd_pc;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_hold;
      end
      EXECR, EXECI: begin
        state_n     = ALUWB;
        alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
        alu_control = dp_alu;
      end
      ALUWB: begin
        reg_write = cond_hold & ~no_write;
        pc_write  = cond_hold & ~no_write & rd_pc;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_hold;
      end
      default: state_n = FETCH;
    endcase
  end

  assign bus.PCWrite    = pc_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01 && !funct[0],
                           op == 2'b10};
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction
// streams checked per cycle against an instruction-level model.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rsrc;
    logic [1:0] aluc;
    logic       asa;
    logic [1:0] asb;
    logic       regw;
  } ctl_t;

  int checks = 0;
  int errors = 0;
  bit mn, mz, mc, mv;
  bit use_af = 1'b0;
  logic [3:0] fixed_af = 4'h0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c);
    bit base;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = mz;
      3'd1: base = mc;
      3'd2: base = mn;
      3'd3: base = mv;
      3'd4: base = mc & ~mz;
      3'd5: base = (mn == mv);
      3'd6: base = ~mz & (mn == mv);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // returns {valid, arith, nowrite, alu[1:0]}
  function automatic logic [4:0] dp_info(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {3'b110, 2'b00};
      4'b0010: return {3'b110, 2'b01};
      4'b0000: return {3'b100, 2'b10};
      4'b1100: return {3'b100, 2'b11};
      4'b1010: return {3'b111, 2'b01};
      default: return {3'b001, 2'b00};
    endcase
  endfunction

  function automatic int latency(input logic [19:0] ins);
    case (ins[15:14])
      2'b01:   return ins[8] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input logic [19:0] ins,
                                      input int k,
                                      input bit ce);
    ctl_t e;
    logic [1:0] op;
    logic [5:0] f;
    logic [4:0] di;
    bit r15;
    op  = ins[15:14];
    f   = ins[13:8];
    r15 = (ins[3:0] == 4'hF);
    di  = dp_info(f[4:1]);
    e   = '0;
    if (k == 0) begin
      e.irw = 1; e.pcw = 1; e.asa = 1;
      e.asb = 2'b10; e.rsrc = 2'b10;
    end else if (k == 1) begin
      e.asa = 1; e.asb = 2'b10; e.rsrc = 2'b10;
    end else if (op == 2'b01) begin
      if (k == 2) e.asb = 2'b01;
      else if (k == 3) begin
        e.adr = 1;
        if (!f[0]) e.memw = ce;
      end else begin
        e.rsrc = 2'b01; e.regw = ce; e.pcw = ce & r15;
      end
    end else if (op == 2'b10) begin
      e.asb = 2'b01; e.rsrc = 2'b10; e.pcw = ce;
    end else if (k == 2) begin
      e.asb  = f[5] ? 2'b01 : 2'b00;
      e.aluc = di[1:0];
    end else begin
      e.regw = ce & ~di[2];
      e.pcw  = ce & ~di[2] & r15;
    end
    return e;
  endfunction

  function automatic ctl_t got_ctl();
    ctl_t g;
    g.pcw  = bus.PCWrite;
    g.adr  = bus.AdrSrc;
    g.memw = bus.MemWrite;
    g.irw  = bus.IRWrite;
    g.rsrc = bus.ResultSrc;
    g.aluc = bus.ALUControl;
    g.asa  = bus.ALUSrcA;
    g.asb  = bus.ALUSrcB;
    g.regw = bus.RegWrite;
    return g;
  endfunction

  function automatic logic [1:0] exp_regsrc(input logic [19:0] ins);
    return {ins[15:14] == 2'b01 && !ins[8], ins[15:14] == 2'b10};
  endfunction

  // called mid-cycle with the DUT in FETCH; runs n steps (0 = all)
  task automatic run_instr(input logic [19:0] ins, input int n);
    bit ce;
    int lat;
    logic [3:0] af;
    logic [4:0] di;
    bus.Instr = ins;
    ce  = cond_ok(ins[19:16]);
    lat = latency(ins);
    if (n > 0 && n < lat) lat = n;
    di  = dp_info(ins[12:9]);
    for (int k = 0; k < lat; k++) begin
      #1;
      chk($sformatf("ctl i%h s%0d", ins, k),
          32'(got_ctl()), 32'(expect_ctl(ins, k, ce)));
      chk($sformatf("imm i%h s%0d", ins, k),
          32'(bus.ImmSrc), 32'(ins[15:14]));
      chk($sformatf("rsel i%h s%0d", ins, k),
          32'(bus.RegSrc), 32'(exp_regsrc(ins)));
      af = use_af ? fixed_af : 4'($urandom);
      bus.ALUFlags = af;
      @(posedge clk);
      if (ins[15:14] == 2'b00 && k == 2 && ce && di[4]
          && (ins[8] || ins[12:9] == 4'b1010)) begin
        mn = af[3];
        mz = af[2];
        if (di[3]) begin
          mc = af[1];
          mv = af[0];
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    ctl_t e;
    e = '0;
    e.asa = 1; e.asb = 2'b10; e.rsrc = 2'b10;
    chk(tag, 32'(got_ctl()), 32'(e));
  endtask

  localparam logic [19:0] ADD_R   = {4'hE, 2'b00, 6'b001000, 4'h2, 4'h1};
  localparam logic [19:0] SUBS_I  = {4'hE, 2'b00, 6'b100101, 4'h1, 4'h1};
  localparam logic [19:0] ADDS_I  = {4'hE, 2'b00, 6'b101001, 4'h1, 4'h1};
  localparam logic [19:0] BEQ     = {4'h0, 2'b10, 6'b000000, 4'h0, 4'h0};
  localparam logic [19:0] LDR_PC  = {4'hE, 2'b01, 6'b011001, 4'h0, 4'hF};
  localparam logic [19:0] STR_NV  = {4'hF, 2'b01, 6'b011000, 4'h0, 4'h1};
  localparam logic [19:0] UNDEF   = {4'hE, 2'b11, 6'b000000, 4'h0, 4'h0};

  initial begin
    logic [19:0] ins;
    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'h0;
    {mn, mz, mc, mv} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset("reset_initial");
    reset = 1'b1;
    run_instr(SUBS_I, 0);

    use_af = 1'b1;
    fixed_af = 4'b0110;
    run_instr(SUBS_I, 0);
    run_instr(BEQ, 0);
    use_af = 1'b0;
    run_instr(ADD_R, 0);
    run_instr(BEQ, 0);
    use_af = 1'b1;
    fixed_af = 4'b0000;
    run_instr(ADDS_I, 0);
    run_instr(BEQ, 0);
    use_af = 1'b0;
    run_instr(LDR_PC, 0);
    run_instr(STR_NV, 0);
    run_instr(UNDEF, 0);

    for (int i = 0; i < 300; i++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
      if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
      run_instr(ins, 0);
    end

    // reset in the middle of an LDR after Z was set
    use_af = 1'b1;
    fixed_af = 4'b0100;
    run_instr(SUBS_I, 0);
    use_af = 1'b0;
    run_instr(LDR_PC, 3);
    #2;
    reset = 1'b0;
    {mn, mz, mc, mv} = 4'b0000;
    #1;
    chk_reset("reset_memrd");
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset("reset_hold");
    bus.Instr = BEQ;
    reset = 1'b1;
    #1;
    chk("irw_after_release", 32'(bus.IRWrite), 32'd1);
    chk("pcw_after_release", 32'(bus.PCWrite), 32'd1);
    run_instr(BEQ, 0);
    run_instr(ADD_R, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle ARM control unit: a state machine that sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback cycles, one instruction at a time. It sits beside the multicycle datapath and replaces the single-cycle decode and condition logic. It holds the NZCV flag register and gates every architectural write with the instruction's condition.

## Interface
Parameters: none.

- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- Instr  input  20  Instr[31:12] from the instruction register:
  - cond = [31:28]
  - op = [27:26]
  - funct = [25:20]
  - Rd = [15:12]
- ALUFlags  input  4  NZCV from the ALU, valid in the execute cycle
- PCWrite  output  1  load PC
- AdrSrc  output  1  memory address: 0 = PC, 1 = ALUResult register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  load instruction register
- ResultSrc  output  2  result mux select:
  - 00 = ALUOut register
  - 01 = Data register
  - 10 = ALU output
- ALUControl  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR
- ALUSrcA  output  1  ALU input A: 0 = RD1, 1 = PC
- ALUSrcB  output  2  ALU input B: 00 = RD2, 01 = ExtImm, 10 = constant 4
- ImmSrc  output  2  equals op
- RegSrc  output  2  register address selects:
  - [0] = 1 when op = 10 (branch)
  - [1] = 1 when op = 01 with funct[0] = 0 (STR)
- RegWrite  output  1  register file write enable

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.

State transitions:
- FETCH → DECODE.
- DECODE, by op:
  - 01 → MEMADR
  - 00 with funct[5] = 0 → EXECR
  - 00 with funct[5] = 1 → EXECI
  - 10 → BRANCH
  - 11 (unsupported) → FETCH
- MEMADR → MEMRD if funct[0] = 1 (LDR), else MEMWR.
- MEMRD → MEMWB.
- EXECR and EXECI → ALUWB.
- MEMWB, MEMWR, ALUWB and BRANCH → FETCH.

Per-state controls (unlisted controls are 0, ResultSrc = 00, ALUControl = ADD):
- FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, IRWrite 1, PCWrite 1 (PC ← PC+4).
- DECODE: ALUSrcA 1, ALUSrcB 10, ResultSrc 10 (R15 reads PC+8).
- MEMADR: ALUSrcA 0, ALUSrcB 01, ADD.
- MEMRD: AdrSrc 1.
- MEMWB: ResultSrc 01, RegWrite = CondEx, PCWrite = CondEx & (Rd == 15).
- MEMWR: AdrSrc 1, MemWrite = CondEx.
- EXECR and EXECI: ALUSrcA 0, ALUSrcB 00 (EXECR) or 01 (EXECI), ALUControl from funct[4:1]:
  - 0100 → ADD
  - 0010 → SUB
  - 0000 → AND
  - 1100 → ORR
  - 1010 (CMP) → SUB with NoWrite
  - any other value → ADD with NoWrite, no flag update
- ALUWB: ResultSrc 00, RegWrite = CondEx & ~NoWrite, PCWrite = CondEx & ~NoWrite & (Rd == 15).
- BRANCH: ALUSrcA 0, ALUSrcB 01, ADD, ResultSrc 10, PCWrite = CondEx.

Condition and flags:
- CondEx is combinational from cond and the flag register, using standard ARM EQ..LE encodings.
- cond 1110 gives CondEx = 1; cond 1111 gives CondEx = 0.
- Flags update only at the end of EXECR/EXECI, only when funct[0] (S) = 1 or the instruction is CMP, and only when CondEx = 1.
  - N and Z always take ALUFlags[3:2].
  - C and V take ALUFlags[1:0] only for ADD, SUB and CMP; they are held for AND and ORR.
- CondEx is evaluated with the pre-update flags.

NoWrite and decoded fields are registered in EXECR/EXECI, or derived combinationally from the stable Instr; either is acceptable because IR holds Instr from DECODE through writeback.

## Timing
- Reset asserted (reset = 0), at any time including mid-instruction:
  - state goes to FETCH and flags go to 0000 immediately.
  - While reset = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Other outputs take their FETCH values.
- First fetch happens on the first rising edge after reset = 1.
- Instruction latency in cycles, FETCH to FETCH:
  - LDR 5
  - STR 4
  - data processing 4
  - B 3
  - op = 11: 2
- All outputs are Moore-style (state plus the stable Instr and flag register). ALUFlags affects only the flag register and never drives outputs combinationally.
- A failed condition still walks the full state path and just suppresses the writes, so latency does not depend on data.

## Test plan
- Reset low mid-MEMRD, then released → state FETCH, all write enables 0 during reset, and IRWrite = PCWrite = 1 in the first cycle after release.
- ADD R1,R2,R3 (cond 1110, op 00, funct 001000) → 4 cycles; RegWrite = 1 only in ALUWB; flags unchanged.
- SUBS R1,R1,#1 with result zero, ALUFlags = 0110 → Z = C = 1 after EXECI; a following BEQ (cond 0000) asserts PCWrite in BRANCH.
- Same BEQ with Z = 0 → PCWrite = 0 in BRANCH; the next FETCH still occurs 3 cycles after the previous fetch.
- LDR R15,[R0] → 5 cycles; MEMWB asserts RegWrite = 1 and PCWrite = 1 with ResultSrc = 01.
- STR with cond 1111 → MEMWR reached with AdrSrc = 1 and MemWrite = 0; op = 11 instruction → DECODE goes directly to FETCH.
